// File: rtl/syn_m_sched.sv
// syn_m_sched: epoch scheduler locking to GPS PPS, with microsecond holdover and fail-over.
// Optional pps_out pulse output is enabled by defining SYN_M_SCHED_PPS_OUT_EN.
module syn_m_sched #(
   parameter int SEC_US      = 1000000,
   parameter int TOL_US      = 100,
   parameter int SYNC_US     = 1000,
   parameter int INFO_DLY_US = 10,
   parameter int HOLD_MAX    = 60
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       pluse_us,
   input  logic       gps_pluse,
   input  logic       info_busy,
   input  logic       ovr_clr,
   output logic       fire_sync,
   output logic       fire_info,
   output logic       locked,
   output logic       holdover,
   output logic       fail,
   output logic       gps_err,
   output logic       info_ovr,
`ifdef SYN_M_SCHED_PPS_OUT_EN
   output logic       pps_out,
`endif
   output logic [1:0] state_dbg
);

   localparam int SW = (SYNC_US > 1) ? $clog2(SYNC_US) : 1;
   localparam int IW = (INFO_DLY_US > 1) ? $clog2(INFO_DLY_US) : 1;
   localparam int HW = $clog2(HOLD_MAX + 1);

   localparam logic [19:0] WIN_LO     = 20'(SEC_US - TOL_US);
   localparam logic [19:0] WIN_HI     = 20'(SEC_US + TOL_US);
   localparam logic [19:0] EPOCH_LAST = 20'(SEC_US - 1);
   localparam logic [19:0] SUB_LIM    = 20'(SEC_US - SYNC_US);
   localparam logic [19:0] US_MAX     = 20'hFFFFF;
   localparam logic [SW-1:0] SUB_LAST  = SW'(SYNC_US - 1);
   localparam logic [IW-1:0] INFO_LAST = IW'(INFO_DLY_US - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1,
      ST_HOLD = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   state_t         st, st_nxt;
   logic [19:0]    us_cnt;
   logic [SW-1:0]  sub_cnt;
   logic [IW-1:0]  info_cnt;
   logic           info_arm;
   logic [HW-1:0]  hold_cnt, hold_nxt;
   logic           gps_s1, gps_s2, gps_s3, gps_rise;
   logic           win, tick_epoch, sec_fire, err_now;
   logic           sub_wrap, sub_fire, info_hit;

   assign state_dbg = st;

   // gps_pluse is asynchronous: two flops to synchronise, a third for edge detect.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         gps_s1   <= 1'b0;
         gps_s2   <= 1'b0;
         gps_s3   <= 1'b0;
         gps_rise <= 1'b0;
      end else begin
         gps_s1   <= gps_pluse;
         gps_s2   <= gps_s1;
         gps_s3   <= gps_s2;
         gps_rise <= gps_s2 & ~gps_s3;
      end
   end

   assign win        = (us_cnt >= WIN_LO) && (us_cnt <= WIN_HI);
   assign tick_epoch = pluse_us && (us_cnt == EPOCH_LAST);

   always_comb begin
      st_nxt   = st;
      hold_nxt = hold_cnt;
      sec_fire = 1'b0;
      err_now  = 1'b0;
      case (st)
         ST_IDLE: begin
            if (gps_rise) begin
               sec_fire = 1'b1;
               hold_nxt = '0;
               st_nxt   = ST_LOCK;
            end
         end
         ST_LOCK: begin
            // A GPS edge in the same cycle as the timeout takes priority.
            if (gps_rise && win) begin
               sec_fire = 1'b1;
            end else if (gps_rise) begin
               err_now = 1'b1;
            end else if (us_cnt >= WIN_HI) begin
               sec_fire = 1'b1;
               hold_nxt = HW'(1);
               st_nxt   = (HOLD_MAX <= 1) ? ST_FAIL : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (gps_rise && win) begin
               sec_fire = 1'b1;
               hold_nxt = '0;
               st_nxt   = ST_LOCK;
            end else begin
               err_now = gps_rise;
               if (tick_epoch) begin
                  sec_fire = 1'b1;
                  hold_nxt = hold_cnt + HW'(1);
                  if (hold_cnt >= HOLD_LAST) st_nxt = ST_FAIL;
               end
            end
         end
         default: begin
            if (gps_rise) begin
               sec_fire = 1'b1;
               hold_nxt = '0;
               st_nxt   = ST_LOCK;
            end else if (tick_epoch) begin
               sec_fire = 1'b1;
            end
         end
      endcase
   end

   assign sub_wrap = (sub_cnt == SUB_LAST);
   assign sub_fire = pluse_us && sub_wrap && !sec_fire && (st != ST_IDLE) && (us_cnt < SUB_LIM);
   assign info_hit = info_arm && pluse_us && (info_cnt == INFO_LAST) && !sec_fire;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         st       <= ST_IDLE;
         hold_cnt <= '0;
         us_cnt   <= '0;
         sub_cnt  <= '0;
      end else begin
         st       <= st_nxt;
         hold_cnt <= hold_nxt;
         if (sec_fire)                          us_cnt <= '0;
         else if (pluse_us && us_cnt != US_MAX) us_cnt <= us_cnt + 20'd1;
         if (sec_fire)      sub_cnt <= '0;
         else if (pluse_us) sub_cnt <= sub_wrap ? '0 : sub_cnt + SW'(1);
      end
   end

   // info_busy is a plain level from the info transmitter: a strike while busy is dropped and flagged.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         info_arm  <= 1'b0;
         info_cnt  <= '0;
         fire_info <= 1'b0;
         info_ovr  <= 1'b0;
      end else begin
         if (sec_fire) begin
            info_arm <= 1'b1;
            info_cnt <= '0;
         end else if (info_hit) begin
            info_arm <= 1'b0;
         end else if (info_arm && pluse_us) begin
            info_cnt <= info_cnt + IW'(1);
         end
         fire_info <= info_hit && !info_busy;
         if (info_hit && info_busy) info_ovr <= 1'b1;
         else if (ovr_clr)          info_ovr <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         fire_sync <= 1'b0;
         gps_err   <= 1'b0;
         locked    <= 1'b0;
         holdover  <= 1'b0;
         fail      <= 1'b0;
      end else begin
         fire_sync <= sec_fire || sub_fire;
         gps_err   <= err_now;
         locked    <= (st_nxt == ST_LOCK);
         holdover  <= (st_nxt == ST_HOLD);
         fail      <= (st_nxt == ST_FAIL);
      end
   end

`ifdef SYN_M_SCHED_PPS_OUT_EN
   localparam logic [6:0] PPS_LAST = 7'd99;
   logic [6:0] pps_cnt;

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         pps_out <= 1'b0;
         pps_cnt <= '0;
      end else if (sec_fire) begin
         pps_out <= 1'b1;
         pps_cnt <= '0;
      end else if (pps_out && pluse_us) begin
         if (pps_cnt == PPS_LAST) pps_out <= 1'b0;
         else                     pps_cnt <= pps_cnt + 7'd1;
      end
   end
`endif

endmodule

// File: tb/tb_syn_m_sched.sv
// Bench for syn_m_sched: directed steps plus randomized microsecond timing and GPS edges,
// checked every cycle against a microsecond-level reference model.
module tb_syn_m_sched;

   localparam int SEC    = 200;
   localparam int TOL    = 10;
   localparam int SYNC   = 50;
   localparam int DLY    = 10;
   localparam int HMAX   = 3;
   localparam int BUDGET = 6000;
   localparam int US_SAT = 1048575;
   localparam int M_IDLE = 0;
   localparam int M_LOCK = 1;
   localparam int M_HOLD = 2;
   localparam int M_FLT  = 3;

   logic       clk_sys   = 1'b0;
   logic       rst       = 1'b1;
   logic       pluse_us  = 1'b0;
   logic       gps_pluse = 1'b0;
   logic       info_busy = 1'b0;
   logic       ovr_clr   = 1'b0;
   logic       fire_sync, fire_info, locked, holdover, fail, gps_err, info_ovr;
   logic [1:0] state_dbg;
`ifdef SYN_M_SCHED_PPS_OUT_EN
   logic       pps_out;
`endif

   always #5 clk_sys = ~clk_sys;

   syn_m_sched #(
      .SEC_US(SEC), .TOL_US(TOL), .SYNC_US(SYNC), .INFO_DLY_US(DLY), .HOLD_MAX(HMAX)
   ) dut (
      .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .gps_pluse(gps_pluse),
      .info_busy(info_busy), .ovr_clr(ovr_clr), .fire_sync(fire_sync), .fire_info(fire_info),
      .locked(locked), .holdover(holdover), .fail(fail), .gps_err(gps_err), .info_ovr(info_ovr),
`ifdef SYN_M_SCHED_PPS_OUT_EN
      .pps_out(pps_out),
`endif
      .state_dbg(state_dbg)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int fs_seen = 0;
   int fi_seen = 0;
   int err_seen = 0;
   bit side_rnd = 1'b0;
   bit busy_lvl = 1'b0;
   bit clr_lvl  = 1'b0;

   // reference model: microseconds since the last epoch and the scheduler mode
   int m_mode  = M_IDLE;
   int m_us    = 0;
   int m_holds = 0;
   bit m_pend  = 1'b0;
   bit m_ovr   = 1'b0;
   bit gin [5];
   logic [6:0] exp_q [$];

   task automatic model_edge(input bit r, input bit pu, input bit g, input bit busy, input bit clr);
      bit rise, win, tick_sec, epoch, err, sub, hit;
      int us0, mode0;
      for (int i = 4; i > 0; i--) gin[i] = gin[i-1];
      gin[0] = g;
      if (r) begin
         foreach (gin[i]) gin[i] = 1'b0;
         m_mode = M_IDLE; m_us = 0; m_holds = 0; m_pend = 1'b0; m_ovr = 1'b0;
         exp_q.push_back(7'd0);
         return;
      end
      us0      = m_us;
      mode0    = m_mode;
      rise     = gin[3] && !gin[4];
      win      = (us0 >= SEC - TOL) && (us0 <= SEC + TOL);
      tick_sec = pu && (us0 + 1 == SEC);
      epoch    = 1'b0;
      err      = 1'b0;
      case (mode0)
         M_IDLE: begin
            if (rise) begin epoch = 1'b1; m_mode = M_LOCK; end
         end
         M_LOCK: begin
            if (rise) begin
               if (win) epoch = 1'b1; else err = 1'b1;
            end else if (us0 >= SEC + TOL) begin
               epoch = 1'b1; m_holds = 1; m_mode = (HMAX <= 1) ? M_FLT : M_HOLD;
            end
         end
         M_HOLD: begin
            if (rise && win) begin
               epoch = 1'b1; m_mode = M_LOCK; m_holds = 0;
            end else begin
               err = rise;
               if (tick_sec) begin
                  epoch = 1'b1;
                  m_holds++;
                  if (m_holds >= HMAX) m_mode = M_FLT;
               end
            end
         end
         default: begin
            if (rise) begin epoch = 1'b1; m_mode = M_LOCK; m_holds = 0; end
            else if (tick_sec) epoch = 1'b1;
         end
      endcase
      sub = pu && !epoch && (mode0 != M_IDLE) && ((us0 + 1) % SYNC == 0) && (us0 + 1 <= SEC - SYNC);
      hit = m_pend && pu && !epoch && (us0 + 1 == DLY);
      if (epoch) m_us = 0;
      else if (pu && m_us < US_SAT) m_us++;
      if (epoch) m_pend = 1'b1;
      else if (hit) m_pend = 1'b0;
      if (hit && busy) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      exp_q.push_back({epoch || sub, hit && !busy, m_mode == M_LOCK, m_mode == M_HOLD,
                       m_mode == M_FLT, err, m_ovr});
   endtask

   task automatic expect_int(input string tag, input int act, input int req);
      n_tests++;
      assert (act === req) else begin
         n_fail++;
         $error("FAIL %s act=%0d req=%0d", tag, act, req);
      end
   endtask

   task automatic check_outputs();
      logic [6:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {fire_sync, fire_info, locked, holdover, fail, gps_err, info_ovr};
      n_tests++;
      assert (act_v === exp_v) else begin
         n_fail++;
         $error("FAIL cycle_outputs t=%0t act=%b req=%b (sync,info,lock,hold,fail,err,ovr)",
                $time, act_v, exp_v);
      end
      if (fire_sync === 1'b1) fs_seen++;
      if (fire_info === 1'b1) fi_seen++;
      if (gps_err === 1'b1)   err_seen++;
   endtask

   task automatic cycle(input bit pu, input bit g);
      bit busy, clr;
      busy = side_rnd ? ($urandom_range(0, 15) == 0) : busy_lvl;
      clr  = side_rnd ? ($urandom_range(0, 31) == 0) : clr_lvl;
      pluse_us = pu; gps_pluse = g; info_busy = busy; ovr_clr = clr;
      @(posedge clk_sys);
      model_edge(rst, pu, g, busy, clr);
      #1;
      check_outputs();
   endtask

   task automatic run_until(input int tgt, input bit g);
      int k;
      k = 0;
      while (m_us != tgt && k < BUDGET) begin
         cycle($urandom_range(0, 1) == 1, g);
         k++;
      end
      n_tests++;
      assert (k < BUDGET) else begin
         n_fail++;
         $error("FAIL wait_us act=%0d req=%0d", m_us, tgt);
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle($urandom_range(0, 1) == 1, 1'b0);
   endtask

   // GPS high for 6 cycles then low; fs_at is the cycle index of the first fire_sync seen
   task automatic gps_edge(output int fs_at);
      fs_at = -1;
      for (int i = 1; i <= 8; i++) begin
         cycle($urandom_range(0, 1) == 1, i <= 6);
         if (fire_sync === 1'b1 && fs_at < 0) fs_at = i;
      end
   endtask

   initial begin
      int fs_at, tgt, r;

      // reset
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      expect_int("rst_outputs", {fire_sync, fire_info, locked, holdover, fail, gps_err, info_ovr}, 0);
      expect_int("rst_state_idle", int'(state_dbg), 0);
      rst = 1'b0;

      // idle, then lock to periodic GPS edges
      run_cycles(40);
      expect_int("idle_no_fire", fs_seen, 0);
      gps_edge(fs_at);
      expect_int("first_lock_latency", fs_at, 4);
      expect_int("first_locked", int'(locked), 1);
      for (int s = 0; s < 2; s++) begin
         fs_seen = 0; fi_seen = 0;
         run_until(SEC - 3, 1'b0);
         gps_edge(fs_at);
         expect_int("fires_per_second", fs_seen, SEC / SYNC);
         expect_int("info_per_second", fi_seen, 1);
      end

      // early in-window edge accepted, mid-second edge rejected
      err_seen = 0;
      run_until(SEC - 5, 1'b0);
      gps_edge(fs_at);
      expect_int("early_edge_no_err", err_seen, 0);
      run_until(SEC / 2, 1'b0);
      fs_seen = 0;
      gps_edge(fs_at);
      expect_int("reject_err", err_seen, 1);
      expect_int("reject_no_fire", fs_seen, 0);
      expect_int("reject_still_locked", int'(locked), 1);
      run_until(SEC - 3, 1'b0);
      gps_edge(fs_at);

      // GPS lost: timeout, holdover epochs, fail, recovery
      run_until(SEC + TOL, 1'b0);
      cycle(1'b0, 1'b0);
      expect_int("timeout_fire", int'(fire_sync), 1);
      expect_int("timeout_holdover", int'(holdover), 1);
      for (int i = 1; i < HMAX; i++) begin
         run_until(SEC - 1, 1'b0);
         cycle(1'b1, 1'b0);
         expect_int("hold_epoch_fire", int'(fire_sync), 1);
         expect_int("hold_to_fail", int'(fail), int'(i == HMAX - 1));
      end
      run_until(SEC / 2, 1'b0);
      gps_edge(fs_at);
      expect_int("fail_recover_locked", int'(locked), 1);
      expect_int("fail_recover_fire", int'(fs_at > 0), 1);

      // info dropped while busy, then cleared
      run_until(SEC - 3, 1'b0);
      busy_lvl = 1'b1;
      gps_edge(fs_at);
      fi_seen = 0;
      run_until(DLY + 2, 1'b0);
      expect_int("busy_no_info", fi_seen, 0);
      expect_int("busy_ovr_set", int'(info_ovr), 1);
      busy_lvl = 1'b0;
      clr_lvl  = 1'b1;
      cycle(1'b0, 1'b0);
      clr_lvl  = 1'b0;
      expect_int("ovr_cleared", int'(info_ovr), 0);

      // GPS edge coincides with the tick at us == SEC
      run_until(SEC, 1'b0);
      fs_seen = 0; err_seen = 0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
      expect_int("coincide_fire", int'(fire_sync), 1);
      for (int i = 0; i < 6; i++) cycle(1'b0, i < 2);
      expect_int("coincide_single_fire", fs_seen, 1);
      expect_int("coincide_no_err", err_seen, 0);
      fs_seen = 0;
      for (int i = 0; i < SYNC; i++) cycle(1'b1, 1'b0);
      expect_int("coincide_us_zeroed", int'(fire_sync), 1);
      expect_int("coincide_one_sub", fs_seen, 1);

      // reset in the middle of holdover
      run_until(SEC + TOL, 1'b0);
      cycle(1'b0, 1'b0);
      run_until(SEC / 2, 1'b0);
      rst = 1'b1;
      cycle(1'b1, 1'b0);
      rst = 1'b0;
      expect_int("midhold_rst_outputs", {fire_sync, fire_info, locked, holdover, fail, gps_err, info_ovr}, 0);
      expect_int("midhold_rst_state", int'(state_dbg), 0);
      fs_seen = 0; fi_seen = 0;
      run_cycles(600);
      expect_int("post_rst_no_sync", fs_seen, 0);
      expect_int("post_rst_no_info", fi_seen, 0);
      gps_edge(fs_at);
      expect_int("post_rst_relock", int'(locked), 1);

      // randomized seconds: edge position, missing edges, busy and clear
      side_rnd = 1'b1;
      for (int s = 0; s < 10; s++) begin
         r = $urandom_range(0, 7);
         if (r == 0) begin
            run_cycles(300);
         end else begin
            if (r <= 2) tgt = $urandom_range(20, SEC - 40);
            else        tgt = $urandom_range(SEC - TOL + 1, SEC + TOL - 4);
            if (m_mode != M_LOCK && tgt > SEC - 2) tgt = SEC - 2;
            run_until(tgt, 1'b0);
            gps_edge(fs_at);
         end
      end
      side_rnd = 1'b0;
      run_cycles(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog t=%0t act=running req=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
